// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer for a single full adder under test.
// Sweeps fault codes 0..4 over all eight input vectors and records which faults were observed.
module fault_campaign_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_sum,
  input  logic       dut_carry,
  output logic [2:0] fault_select,
  output logic       a,
  output logic       b,
  output logic       cin,
  output logic       busy,
  output logic       done,
  output logic [4:0] detect_map,
  output logic [2:0] detect_count,
  output logic [5:0] mismatch_count,
  output logic       golden_err,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;

  state_t     state_q, state_d;
  logic [2:0] f_q, f_d;
  logic [2:0] v_q, v_d;
  logic [2:0] fault_select_q, fault_select_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [4:0] detect_map_q, detect_map_d;
  logic [2:0] detect_count_q, detect_count_d;
  logic [5:0] mismatch_count_q, mismatch_count_d;
  logic       golden_err_q, golden_err_d;

  logic golden_sum, golden_carry, mismatch;

  // Golden reference is taken from the vector currently driven to the adder.
  assign golden_sum   = abc_q[2] ^ abc_q[1] ^ abc_q[0];
  assign golden_carry = (abc_q[2] & abc_q[1]) | (abc_q[2] & abc_q[0]) | (abc_q[1] & abc_q[0]);
  assign mismatch     = (dut_sum != golden_sum) || (dut_carry != golden_carry);

  always_comb begin
    state_d          = state_q;
    f_d              = f_q;
    v_d              = v_q;
    detect_map_d     = detect_map_q;
    mismatch_count_d = mismatch_count_q;
    golden_err_d     = golden_err_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d          = APPLY;
          f_d              = 3'd0;
          v_d              = 3'd0;
          detect_map_d     = 5'd0;
          mismatch_count_d = 6'd0;
          golden_err_d     = 1'b0;
        end
      end
      APPLY: begin
        state_d = abort ? IDLE : SAMPLE;
      end
      SAMPLE: begin
        // A mismatch seen in this SAMPLE is kept even when abort ends the campaign.
        if (mismatch) begin
          mismatch_count_d = (mismatch_count_q == 6'd63) ? mismatch_count_q : mismatch_count_q + 6'd1;
          detect_map_d     = detect_map_q | (5'd1 << f_q);
          if (f_q == 3'd0) golden_err_d = 1'b1;
        end
        if (abort) begin
          state_d = IDLE;
        end else if (v_q != 3'd7) begin
          v_d     = v_q + 3'd1;
          state_d = APPLY;
        end else if (f_q != 3'd4) begin
          f_d     = f_q + 3'd1;
          v_d     = 3'd0;
          state_d = APPLY;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    fault_select_d = 3'd0;
    abc_d          = 3'd0;
    case (state_d)
      APPLY: begin
        fault_select_d = f_d;
        abc_d          = v_d;
      end
      SAMPLE: begin
        fault_select_d = fault_select_q;
        abc_d          = abc_q;
      end
      default: ;
    endcase
    busy_d         = (state_d == APPLY) || (state_d == SAMPLE);
    done_d         = (state_d == DONE);
    detect_count_d = {2'b00, detect_map_d[1]} + {2'b00, detect_map_d[2]}
                   + {2'b00, detect_map_d[3]} + {2'b00, detect_map_d[4]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      f_q              <= 3'd0;
      v_q              <= 3'd0;
      fault_select_q   <= 3'd0;
      abc_q            <= 3'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      detect_map_q     <= 5'd0;
      detect_count_q   <= 3'd0;
      mismatch_count_q <= 6'd0;
      golden_err_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      f_q              <= f_d;
      v_q              <= v_d;
      fault_select_q   <= fault_select_d;
      abc_q            <= abc_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      detect_map_q     <= detect_map_d;
      detect_count_q   <= detect_count_d;
      mismatch_count_q <= mismatch_count_d;
      golden_err_q     <= golden_err_d;
    end
  end

  assign fault_select   = fault_select_q;
  assign a              = abc_q[2];
  assign b              = abc_q[1];
  assign cin            = abc_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign detect_map     = detect_map_q;
  assign detect_count   = detect_count_q;
  assign mismatch_count = mismatch_count_q;
  assign golden_err     = golden_err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl with a behavioural fault-injectable adder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fault_campaign_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       dut_sum, dut_carry;
  logic [2:0] fault_select;
  logic       a, b, cin, busy, done;
  logic [4:0] detect_map;
  logic [2:0] detect_count;
  logic [5:0] mismatch_count;
  logic       golden_err;
  logic [1:0] state_o;
  logic       force_sum0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fault_campaign_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dut_sum(dut_sum), .dut_carry(dut_carry),
    .fault_select(fault_select), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .detect_map(detect_map),
    .detect_count(detect_count), .mismatch_count(mismatch_count),
    .golden_err(golden_err), .state_o(state_o)
  );

  // Adder under test; force_sum0 models a broken sum output regardless of fault code.
  always_comb begin
    dut_sum   = a ^ b ^ cin;
    dut_carry = (a & b) | (a & cin) | (b & cin);
    case (fault_select)
      3'd1: dut_sum   = 1'b0;
      3'd2: dut_sum   = 1'b1;
      3'd3: dut_carry = 1'b0;
      3'd4: dut_carry = 1'b1;
      default: ;
    endcase
    if (force_sum0) dut_sum = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until done is seen or the budget expires; returns the cycle number reached.
  task automatic wait_done(input int from, output int at);
    at = from;
    while (done !== 1'b1 && at < from + 300) begin
      step(1);
      at++;
    end
  endtask

  task automatic check_results(input string tag, input logic [4:0] map, input logic [2:0] cnt,
                               input logic [5:0] mc, input logic ge);
    check({tag, "_map"}, {27'd0, detect_map}, {27'd0, map});
    check({tag, "_cnt"}, {29'd0, detect_count}, {29'd0, cnt});
    check({tag, "_mc"}, {26'd0, mismatch_count}, {26'd0, mc});
    check({tag, "_ge"}, {31'd0, golden_err}, {31'd0, ge});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fs"}, {29'd0, fault_select}, 32'd0);
    check({tag, "_abc"}, {29'd0, a, b, cin}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_state"}, {30'd0, state_o}, 32'd0);
    check_results(tag, 5'b00000, 3'd0, 6'd0, 1'b0);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int first_done;
    int second_done;
    logic busy82, busy83;
    logic done_seen;

    rst = 1'b1; start = 1'b0; abort = 1'b0; force_sum0 = 1'b0;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    step(1);

    // Correct adder: full campaign.
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("c1_busy", {31'd0, busy}, 32'd1);
    check("c1_state_apply", {30'd0, state_o}, 32'd1);
    step(2);
    check("c1_abc_v1", {29'd0, a, b, cin}, 32'd1);
    check("c1_fs_v1", {29'd0, fault_select}, 32'd0);
    wait_done(3, cyc);
    check("c1_done_cycle", cyc, 32'd81);
    check("c1_busy_at_done", {31'd0, busy}, 32'd0);
    check_results("c1", 5'b11110, 3'd4, 6'd16, 1'b0);
    step(1);
    check("c1_done_pulse_width", {31'd0, done}, 32'd0);
    check("c1_idle", {30'd0, state_o}, 32'd0);

    // Sum forced to 0: misses per fault code are 4,4,4,7,5.
    force_sum0 = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(1, cyc);
    check("c2_done_cycle", cyc, 32'd81);
    check_results("c2", 5'b11111, 3'd4, 6'd24, 1'b1);
    step(1);

    // abort and start together in IDLE.
    abort = 1'b1; start = 1'b1;
    step(3);
    check("c3_busy", {31'd0, busy}, 32'd0);
    check_results("c3_keep", 5'b11111, 3'd4, 6'd24, 1'b1);
    abort = 1'b0; start = 1'b0;
    force_sum0 = 1'b0;
    step(1);

    // Abort in the SAMPLE of f=2, v=0 (cycle 34).
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(33);
    check("c4_state_sample", {30'd0, state_o}, 32'd2);
    check("c4_fs", {29'd0, fault_select}, 32'd2);
    check("c4_abc", {29'd0, a, b, cin}, 32'd0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("c4_state_idle", {30'd0, state_o}, 32'd0);
    check("c4_busy", {31'd0, busy}, 32'd0);
    check("c4_fs_idle", {29'd0, fault_select}, 32'd0);
    check_results("c4", 5'b00110, 3'd2, 6'd5, 1'b0);
    done_seen = done;
    for (int i = 0; i < 6; i++) begin
      step(1);
      done_seen = done_seen | done;
    end
    check("c4_no_done", {31'd0, done_seen}, 32'd0);

    // Reset at cycle 40 of a campaign, then a fresh campaign.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(39);
    check("c5_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_outputs("c5_rst");
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(1, cyc);
    check("c5_done_cycle", cyc, 32'd81);
    check_results("c5", 5'b11110, 3'd4, 6'd16, 1'b0);
    step(1);

    // start held high for 200 cycles.
    start = 1'b1;
    done_cnt = 0; first_done = 0; second_done = 0;
    busy82 = 1'bx; busy83 = 1'bx;
    for (int c = 1; c <= 200; c++) begin
      step(1);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) first_done = c;
        if (done_cnt == 2) second_done = c;
      end
      if (c == 81) check("c6_mc_at_done", {26'd0, mismatch_count}, 32'd16);
      if (c == 82) busy82 = busy;
      if (c == 83) busy83 = busy;
    end
    start = 1'b0;
    check("c6_first_done", first_done, 32'd81);
    check("c6_second_done", second_done, 32'd163);
    check("c6_done_count", done_cnt, 32'd2);
    check("c6_busy82", {31'd0, busy82}, 32'd0);
    check("c6_busy83", {31'd0, busy83}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
